// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back initiator: round-robin arbitration between ALU and
// memory results, a registered write port, and a pending-destination scoreboard.
module regfile_wb_arbiter #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int IW   = $clog2(NREG),
  localparam int CW   = $clog2(NREG) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [IW-1:0]   issue_rd,
  input  logic [IW-1:0]   issue_rs1,
  input  logic [IW-1:0]   issue_rs2,
  output logic            issue_stall,
  input  logic            alu_valid,
  input  logic [IW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [IW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  output logic            wb_load,
  output logic [IW-1:0]   wb_dest,
  output logic [XLEN-1:0] wb_data,
  output logic [CW-1:0]   pending_count
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  src_e            rr_ptr;
  logic [NREG-1:1] busy_q;
  logic [NREG-1:0] busy, busy_nxt, set_mask, clr_mask;
  logic [CW-1:0]   cnt_nxt;
  logic            issue_set;

  // x0 has no storage, so it can never be reported busy (even before reset)
  assign busy = {busy_q, 1'b0};

  assign alu_ready   = alu_valid && (!mem_valid || rr_ptr == SRC_ALU);
  assign mem_ready   = mem_valid && (!alu_valid || rr_ptr == SRC_MEM);
  assign issue_stall = busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd];
  assign issue_set   = issue_valid && !issue_stall && (issue_rd != '0);

  // Clear is applied before set so a same-index set wins
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_set) set_mask[issue_rd] = 1'b1;
    if (wb_load)   clr_mask[wb_dest]  = 1'b1;
    busy_nxt    = (busy & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 1; i < NREG; i++) cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= SRC_ALU;
      busy_q        <= '0;
      pending_count <= '0;
      wb_load       <= 1'b0;
      wb_dest       <= '0;
      wb_data       <= '0;
    end else begin
      busy_q        <= busy_nxt[NREG-1:1];
      pending_count <= cnt_nxt;
      if (alu_valid && mem_valid)
        rr_ptr <= (rr_ptr == SRC_ALU) ? SRC_MEM : SRC_ALU;
      if (alu_ready) begin
        wb_load <= (alu_rd != '0);
        wb_dest <= alu_rd;
        wb_data <= alu_data;
      end else if (mem_ready) begin
        wb_load <= (mem_rd != '0);
        wb_dest <= mem_rd;
        wb_data <= mem_data;
      end else begin
        wb_load <= 1'b0;
      end
    end
  end

endmodule
